// File: rtl/spram_arbiter.sv
// Two-port round-robin front end for a single iCE40 SPRAM macro (16K x 16).
// Adds idle-driven STANDBY entry and a timed wake-up sequence.
module spram_arbiter #(
  parameter int IDLE_CYCLES = 64,
  parameter int WAKE_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        a_valid,
  output logic        a_ready,
  input  logic        a_write,
  input  logic [13:0] a_addr,
  input  logic [15:0] a_wdata,
  input  logic [3:0]  a_mask,
  output logic        a_rsp_valid,
  output logic [15:0] a_rsp_data,

  input  logic        b_valid,
  output logic        b_ready,
  input  logic        b_write,
  input  logic [13:0] b_addr,
  input  logic [15:0] b_wdata,
  input  logic [3:0]  b_mask,
  output logic        b_rsp_valid,
  output logic [15:0] b_rsp_data,

  output logic [13:0] ram_address,
  output logic [15:0] ram_datain,
  output logic [3:0]  ram_maskwren,
  output logic        ram_wren,
  output logic        ram_chipselect,
  output logic        ram_standby,
  output logic        ram_sleep,
  output logic        ram_poweroff,
  input  logic [15:0] ram_dataout,

  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_ACTIVE  = 2'd0,
    ST_STANDBY = 2'd1,
    ST_WAKE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] WAKE_LIMIT = CNT_W'(WAKE_CYCLES);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cnt_inc;
  logic              last_b_q, last_b_d;
  logic              a_rsp_valid_q, a_rsp_valid_d;
  logic              b_rsp_valid_q, b_rsp_valid_d;
  logic              grant_a, grant_b;
  logic              any_valid;

  // Handshake: a command transfers in any cycle where x_valid && x_ready are both
  // high; the requester holds valid and all fields stable until that happens, and
  // ready is only ever raised in ACTIVE, for at most one requester per cycle.

  assign any_valid = a_valid | b_valid;
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_ACTIVE) begin
      if (a_valid && b_valid) begin
        grant_a = last_b_q;
        grant_b = !last_b_q;
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= ST_ACTIVE;
      cnt_q         <= '0;
      last_b_q      <= 1'b1;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_b_q      <= last_b_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      b_rsp_valid_q <= b_rsp_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_b_d = last_b_q;
    case (state_q)
      ST_ACTIVE: begin
        if (any_valid) begin
          cnt_d = '0;
        end else if (IDLE_CYCLES != 0) begin
          cnt_d = cnt_inc;
          if (cnt_inc == IDLE_LIMIT) begin
            state_d = ST_STANDBY;
          end
        end
        if (grant_a) last_b_d = 1'b0;
        if (grant_b) last_b_d = 1'b1;
      end
      ST_STANDBY: begin
        if (any_valid) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        cnt_d = cnt_inc;
        if (cnt_inc == WAKE_LIMIT) begin
          state_d = ST_ACTIVE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_ACTIVE;
        cnt_d   = '0;
      end
    endcase
    // SPRAM output register makes read data visible exactly one cycle after accept.
    a_rsp_valid_d = grant_a && !a_write;
    b_rsp_valid_d = grant_b && !b_write;
  end

  // Output logic
  always_comb begin
    a_ready        = grant_a;
    b_ready        = grant_b;
    ram_chipselect = grant_a | grant_b;
    ram_wren       = (grant_a & a_write) | (grant_b & b_write);
    ram_address    = grant_b ? b_addr  : a_addr;
    ram_datain     = grant_b ? b_wdata : a_wdata;
    ram_maskwren   = grant_b ? b_mask  : a_mask;
    ram_standby    = (state_q == ST_STANDBY);
    ram_sleep      = 1'b0;
    ram_poweroff   = 1'b1;
    state_dbg      = state_q;
  end

  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign a_rsp_data  = ram_dataout;
  assign b_rsp_data  = ram_dataout;

endmodule

// File: tb/tb_spram_arbiter.sv
// Randomized and directed bench for spram_arbiter with a behavioural SPRAM,
// a cycle-level availability/grant model and per-requester response queues.
module tb_spram_arbiter;

  localparam int IDLE = 4;
  localparam int WAKE = 3;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  valid, write, ready, rsp_valid;
  logic [13:0] addr[2];
  logic [15:0] wdata[2];
  logic [3:0]  mask[2];
  logic [15:0] rsp_data[2];

  logic [13:0] ram_address;
  logic [15:0] ram_datain;
  logic [3:0]  ram_maskwren;
  logic        ram_wren, ram_chipselect, ram_standby, ram_sleep, ram_poweroff;
  logic [15:0] ram_dataout;
  logic [1:0]  state_dbg;

  spram_arbiter #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(8)) dut (
    .clk(clk), .resetn(resetn),
    .a_valid(valid[0]), .a_ready(ready[0]), .a_write(write[0]), .a_addr(addr[0]),
    .a_wdata(wdata[0]), .a_mask(mask[0]), .a_rsp_valid(rsp_valid[0]), .a_rsp_data(rsp_data[0]),
    .b_valid(valid[1]), .b_ready(ready[1]), .b_write(write[1]), .b_addr(addr[1]),
    .b_wdata(wdata[1]), .b_mask(mask[1]), .b_rsp_valid(rsp_valid[1]), .b_rsp_data(rsp_data[1]),
    .ram_address(ram_address), .ram_datain(ram_datain), .ram_maskwren(ram_maskwren),
    .ram_wren(ram_wren), .ram_chipselect(ram_chipselect), .ram_standby(ram_standby),
    .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff), .ram_dataout(ram_dataout),
    .state_dbg(state_dbg)
  );

  // Behavioural SPRAM: registered read, nibble-masked write.
  logic [15:0] ram_mem[16384];
  always @(posedge clk) begin
    if (ram_chipselect && !ram_standby) begin
      if (ram_wren) begin
        for (int i = 0; i < 4; i++)
          if (ram_maskwren[i]) ram_mem[ram_address][4*i +: 4] <= ram_datain[4*i +: 4];
      end else begin
        ram_dataout <= ram_mem[ram_address];
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: expected memory, availability mode and fairness history.
  logic [15:0] shadow[16384];
  logic [15:0] exp_q[2][$];
  int          exp_cyc_q[2][$];
  int          mode = 0;        // 0 serving, 1 asleep, 2 waking
  int          idle_run = 0;
  int          wake_left = 0;
  bit          last_b = 1'b1;
  int          cyc = 0;

  task automatic model_step();
    int g;
    logic [1:0] exp_ready;
    logic exp_stby;
    g = -1;
    exp_ready = 2'b00;
    exp_stby = (mode == 1);
    case (mode)
      0: begin
        if (valid != 2'b00) begin
          if (valid == 2'b11) g = last_b ? 0 : 1;
          else g = valid[0] ? 0 : 1;
          exp_ready[g] = 1'b1;
          last_b = (g == 1);
          idle_run = 0;
        end else begin
          idle_run++;
          if (IDLE != 0 && idle_run == IDLE) mode = 1;
        end
      end
      1: begin
        if (valid != 2'b00) begin
          mode = 2;
          wake_left = WAKE;
        end
      end
      default: begin
        wake_left--;
        if (wake_left == 0) begin
          mode = 0;
          idle_run = 0;
        end
      end
    endcase
    check("ready", {30'b0, ready}, {30'b0, exp_ready});
    check("standby", {31'b0, ram_standby}, {31'b0, exp_stby});
    check("chipselect", {31'b0, ram_chipselect}, {31'b0, (g >= 0)});
    if (g >= 0) begin
      check("wren", {31'b0, ram_wren}, {31'b0, write[g]});
      if (write[g]) begin
        for (int i = 0; i < 4; i++)
          if (mask[g][i]) shadow[addr[g]][4*i +: 4] = wdata[g][4*i +: 4];
      end else begin
        exp_q[g].push_back(shadow[addr[g]]);
        exp_cyc_q[g].push_back(cyc + 1);
      end
    end
  endtask

  // Monitor: compares responses against the queues, then advances the model.
  always @(negedge clk) begin
    if (!resetn) begin
      check("rsp_valid_in_reset", {30'b0, rsp_valid}, 32'd0);
      for (int r = 0; r < 2; r++) begin
        exp_q[r].delete();
        exp_cyc_q[r].delete();
      end
      mode = 0;
      idle_run = 0;
      wake_left = 0;
      last_b = 1'b1;
    end else begin
      cyc++;
      for (int r = 0; r < 2; r++) begin
        if (rsp_valid[r]) begin
          if (exp_q[r].size() == 0) begin
            check(r == 0 ? "a_rsp_unexpected" : "b_rsp_unexpected", {31'b0, rsp_valid[r]}, 32'd0);
          end else begin
            check(r == 0 ? "a_rsp_data" : "b_rsp_data", {16'b0, rsp_data[r]}, {16'b0, exp_q[r].pop_front()});
            check(r == 0 ? "a_rsp_cycle" : "b_rsp_cycle", cyc, exp_cyc_q[r].pop_front());
          end
        end else if (exp_cyc_q[r].size() != 0 && exp_cyc_q[r][0] <= cyc) begin
          check(r == 0 ? "a_rsp_missing" : "b_rsp_missing", {31'b0, rsp_valid[r]}, 32'd1);
          void'(exp_q[r].pop_front());
          void'(exp_cyc_q[r].pop_front());
        end
      end
      model_step();
    end
  end

  // Driver tasks: all start and end at posedge + 1.
  task automatic wait_accept(input int r);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (ready[r]) got = 1'b1;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic access(input int r, input bit w, input logic [13:0] ad,
                        input logic [15:0] d, input logic [3:0] m);
    valid[r] = 1'b1; write[r] = w; addr[r] = ad; wdata[r] = d; mask[r] = m;
    wait_accept(r);
    @(posedge clk); #1;
    valid[r] = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic new_random(input int r);
    valid[r] = 1'b1;
    write[r] = ($urandom_range(0, 1) == 1);
    addr[r]  = 14'($urandom_range(0, 31));
    wdata[r] = 16'($urandom);
    mask[r]  = 4'($urandom_range(0, 15));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] acc;
    bit quiet;
    valid = 2'b00; write = 2'b00;
    for (int r = 0; r < 2; r++) begin
      addr[r] = '0; wdata[r] = '0; mask[r] = '0;
    end
    for (int i = 0; i < 16384; i++) begin
      ram_mem[i] = 16'h0000;
      shadow[i]  = 16'h0000;
    end

    // Reset values
    @(negedge clk);
    check("rst_standby", {31'b0, ram_standby}, 32'd0);
    check("rst_chipselect", {31'b0, ram_chipselect}, 32'd0);
    check("rst_wren", {31'b0, ram_wren}, 32'd0);
    check("rst_sleep", {31'b0, ram_sleep}, 32'd0);
    check("rst_poweroff", {31'b0, ram_poweroff}, 32'd1);
    check("rst_state", {30'b0, state_dbg}, 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Full write then read-back
    access(0, 1'b1, 14'h0010, 16'hBEEF, 4'hF);
    access(0, 1'b0, 14'h0010, 16'h0000, 4'h0);
    // Nibble-masked merge: expect 0x1B3D
    access(0, 1'b1, 14'h0011, 16'h1234, 4'hF);
    access(0, 1'b1, 14'h0011, 16'hABCD, 4'h5);
    access(0, 1'b0, 14'h0011, 16'h0000, 4'h0);
    // Read immediately before a write to the same address sees the old value
    access(1, 1'b0, 14'h0010, 16'h0000, 4'h0);
    access(1, 1'b1, 14'h0010, 16'h0F0F, 4'hF);
    access(1, 1'b0, 14'h0010, 16'h0000, 4'h0);

    // Both requesters reading continuously: grants alternate
    valid = 2'b11; write = 2'b00;
    addr[0] = 14'h0010; addr[1] = 14'h0011;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = valid & ready;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) if (acc[r]) addr[r] = addr[r] + 14'd1;
    end
    valid = 2'b00;

    // Idle into standby, then B read rides through the wake sequence
    idle_cycles(8);
    access(1, 1'b0, 14'h0010, 16'h0000, 4'h0);

    // Reset the cycle after a read is accepted: its response is discarded
    access(0, 1'b1, 14'h0020, 16'h5A5A, 4'hF);
    valid[0] = 1'b1; write[0] = 1'b0; addr[0] = 14'h0020;
    wait_accept(0);
    @(posedge clk); #1;
    resetn = 1'b0;
    valid[0] = 1'b0;
    idle_cycles(2);
    resetn = 1'b1;
    access(0, 1'b0, 14'h0020, 16'h0000, 4'h0);

    // A streams continuously with B idle: ready every cycle, no standby
    new_random(0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      acc = valid & ready;
      @(posedge clk); #1;
      if (acc[0]) new_random(0);
    end
    valid = 2'b00;

    // Random traffic with periodic quiet windows that reach standby
    for (int i = 0; i < 1500; i++) begin
      quiet = ((i % 150) < 12);
      @(negedge clk);
      acc = valid & ready;
      @(posedge clk); #1;
      for (int r = 0; r < 2; r++) begin
        if (!valid[r] || acc[r]) begin
          if (!quiet && $urandom_range(0, 99) < 55) new_random(r);
          else valid[r] = 1'b0;
        end
      end
    end
    while (valid != 2'b00) begin
      @(negedge clk);
      acc = valid & ready;
      @(posedge clk); #1;
      valid = valid & ~acc;
      if (cyc > 60000) begin
        check("drain_timeout", 32'd0, 32'd1);
        valid = 2'b00;
      end
    end

    idle_cycles(4);
    @(negedge clk);
    check("queues_drained", exp_q[0].size() + exp_q[1].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
